// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame constants and
// baud_select codes used by both the transmit and receive paths.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rx_state_t;

    localparam int DATA_BITS  = 8;
    localparam int OVERSAMPLE = 16;
    localparam int MID_TICK   = 7;
    localparam int LAST_TICK  = 15;

    localparam int CLK_HZ = 50_000_000;

    localparam logic [2:0] BAUD_300    = 3'b000;
    localparam logic [2:0] BAUD_1200   = 3'b001;
    localparam logic [2:0] BAUD_4800   = 3'b010;
    localparam logic [2:0] BAUD_9600   = 3'b011;
    localparam logic [2:0] BAUD_19200  = 3'b100;
    localparam logic [2:0] BAUD_38400  = 3'b101;
    localparam logic [2:0] BAUD_57600  = 3'b110;
    localparam logic [2:0] BAUD_115200 = 3'b111;

    function automatic int baud_rate(input logic [2:0] sel);
        case (sel)
            BAUD_300:    return 300;
            BAUD_1200:   return 1200;
            BAUD_4800:   return 4800;
            BAUD_9600:   return 9600;
            BAUD_19200:  return 19200;
            BAUD_38400:  return 38400;
            BAUD_57600:  return 57600;
            default:     return 115200;
        endcase
    endfunction

    // clk cycles per oversampling tick, rounded to nearest
    function automatic logic [13:0] baud_div(input logic [2:0] sel);
        int tick_hz;
        tick_hz = OVERSAMPLE * baud_rate(sel);
        return 14'((CLK_HZ + tick_hz / 2) / tick_hz);
    endfunction

endpackage

// File: rtl/baud_controller.sv
// Generates a one-clk sample_ENABLE pulse at 16x the selected baud rate.
module baud_controller
    import uart_pkg::*;
(
    input  logic       reset,
    input  logic       clk,
    input  logic [2:0] baud_select,
    output logic       sample_ENABLE
);

    logic [13:0] div_cnt;
    logic [13:0] div_last;

    assign div_last = baud_div(baud_select) - 14'd1;

    // >= keeps the counter bounded if baud_select shrinks mid-count
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt       <= '0;
            sample_ENABLE <= 1'b0;
        end else if (div_cnt >= div_last) begin
            div_cnt       <= '0;
            sample_ENABLE <= 1'b1;
        end else begin
            div_cnt       <= div_cnt + 14'd1;
            sample_ENABLE <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// UART receiver: 8 data bits LSB first, even parity, 1 stop bit, sampled
// at bit midpoints on a 16x oversampling tick.
module uart_receiver
    import uart_pkg::*;
(
    input  logic       reset,
    input  logic       clk,
    input  logic [2:0] baud_select,
    input  logic       Rx_EN,
    input  logic       RxD,
    output logic [7:0] Rx_DATA,
    output logic       Rx_VALID,
    output logic       Rx_PERROR,
    output logic       Rx_FERROR
);

    logic       sample_ENABLE;
    logic       rxd_meta;
    logic       RxD_s;
    rx_state_t  state;
    logic [3:0] tick_cnt;
    logic [2:0] bit_idx;
    logic [7:0] shreg;
    logic       par_bit;

    baud_controller u_baud (
        .reset         (reset),
        .clk           (clk),
        .baud_select   (baud_select),
        .sample_ENABLE (sample_ENABLE)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rxd_meta <= 1'b1;
            RxD_s    <= 1'b1;
        end else begin
            rxd_meta <= RxD;
            RxD_s    <= rxd_meta;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            tick_cnt  <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            par_bit   <= 1'b0;
            Rx_DATA   <= '0;
            Rx_VALID  <= 1'b0;
            Rx_PERROR <= 1'b0;
            Rx_FERROR <= 1'b0;
        end else begin
            Rx_VALID  <= 1'b0;
            Rx_PERROR <= 1'b0;
            Rx_FERROR <= 1'b0;
            if (!Rx_EN) begin
                state    <= IDLE;
                tick_cnt <= '0;
                bit_idx  <= '0;
            end else if (sample_ENABLE) begin
                case (state)
                    IDLE: begin
                        tick_cnt <= '0;
                        if (!RxD_s) state <= START;
                    end
                    START: begin
                        if (tick_cnt == 4'(MID_TICK)) begin
                            tick_cnt <= '0;
                            bit_idx  <= '0;
                            state    <= RxD_s ? IDLE : DATA;
                        end else begin
                            tick_cnt <= tick_cnt + 4'd1;
                        end
                    end
                    DATA: begin
                        if (tick_cnt == 4'(LAST_TICK)) begin
                            shreg    <= {RxD_s, shreg[7:1]};
                            tick_cnt <= '0;
                            if (bit_idx == 3'(DATA_BITS - 1)) begin
                                bit_idx <= '0;
                                state   <= PARITY;
                            end else begin
                                bit_idx <= bit_idx + 3'd1;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 4'd1;
                        end
                    end
                    PARITY: begin
                        if (tick_cnt == 4'(LAST_TICK)) begin
                            par_bit  <= RxD_s;
                            tick_cnt <= '0;
                            state    <= STOP;
                        end else begin
                            tick_cnt <= tick_cnt + 4'd1;
                        end
                    end
                    STOP: begin
                        if (tick_cnt == 4'(LAST_TICK)) begin
                            tick_cnt <= '0;
                            // framing error wins; parity is meaningless without a stop bit
                            if (!RxD_s) begin
                                Rx_FERROR <= 1'b1;
                                state     <= BREAK;
                            end else if ((^shreg) != par_bit) begin
                                Rx_PERROR <= 1'b1;
                                state     <= IDLE;
                            end else begin
                                Rx_DATA  <= shreg;
                                Rx_VALID <= 1'b1;
                                state    <= IDLE;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 4'd1;
                        end
                    end
                    BREAK: begin
                        tick_cnt <= '0;
                        if (RxD_s) state <= IDLE;
                    end
                    default: begin
                        tick_cnt <= '0;
                        state    <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at 115200 baud: frame table plus
// hand-written false-start, enable-drop and mid-frame reset sequences.
module tb_uart_receiver;
    import uart_pkg::*;

    localparam int BIT_CLK = 432;

    logic       reset;
    logic       clk;
    logic [2:0] baud_select;
    logic       Rx_EN;
    logic       RxD;
    logic [7:0] Rx_DATA;
    logic       Rx_VALID;
    logic       Rx_PERROR;
    logic       Rx_FERROR;

    int n_tests = 0;
    int n_fail  = 0;
    int n_valid = 0;
    int n_perr  = 0;
    int n_ferr  = 0;

    uart_receiver dut (
        .reset       (reset),
        .clk         (clk),
        .baud_select (baud_select),
        .Rx_EN       (Rx_EN),
        .RxD         (RxD),
        .Rx_DATA     (Rx_DATA),
        .Rx_VALID    (Rx_VALID),
        .Rx_PERROR   (Rx_PERROR),
        .Rx_FERROR   (Rx_FERROR)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    always @(negedge clk) begin
        if (Rx_VALID)  n_valid <= n_valid + 1;
        if (Rx_PERROR) n_perr  <= n_perr + 1;
        if (Rx_FERROR) n_ferr  <= n_ferr + 1;
    end

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       stop;
        int         hold_bits;
        int         exp_v;
        int         exp_p;
        int         exp_f;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] data, input logic par,
                              input logic stop, input int hold_bits);
        RxD = 1'b0;
        wait_clk(BIT_CLK);
        for (int i = 0; i < 8; i++) begin
            RxD = data[i];
            wait_clk(BIT_CLK);
        end
        RxD = par;
        wait_clk(BIT_CLK);
        RxD = stop;
        wait_clk(BIT_CLK);
        if (hold_bits > 0) begin
            RxD = 1'b0;
            wait_clk(hold_bits * BIT_CLK);
        end
        RxD = 1'b1;
    endtask

    task automatic check_counts(input string name, input int v0, input int p0,
                                input int f0, input int ev, input int ep, input int ef);
        check({name, "_valid"}, n_valid - v0, ev);
        check({name, "_perr"},  n_perr - p0,  ep);
        check({name, "_ferr"},  n_ferr - f0,  ef);
    endtask

    initial begin
        int v0, p0, f0;

        //           data   par   stop hold v p f  exp_data
        vecs[0] = '{8'hA5, 1'b0, 1'b1, 0, 1, 0, 0, 8'hA5};
        vecs[1] = '{8'h01, 1'b0, 1'b1, 0, 0, 1, 0, 8'hA5};
        vecs[2] = '{8'h3C, 1'b0, 1'b0, 5, 0, 0, 1, 8'hA5};
        vecs[3] = '{8'h3C, 1'b0, 1'b1, 0, 1, 0, 0, 8'h3C};
        vecs[4] = '{8'h80, 1'b1, 1'b1, 0, 1, 0, 0, 8'h80};
        vecs[5] = '{8'h55, 1'b1, 1'b1, 0, 0, 1, 0, 8'h80};
        vecs[6] = '{8'h7F, 1'b1, 1'b1, 0, 1, 0, 0, 8'h7F};

        reset       = 1'b1;
        baud_select = BAUD_115200;
        Rx_EN       = 1'b1;
        RxD         = 1'b1;
        wait_clk(5);
        check("rst_data",  Rx_DATA, 8'h00);
        check("rst_valid", Rx_VALID, 0);
        check("rst_perr",  Rx_PERROR, 0);
        check("rst_ferr",  Rx_FERROR, 0);
        check("rst_state", dut.state, IDLE);
        reset = 1'b0;
        wait_clk(BIT_CLK);

        for (int i = 0; i < 7; i++) begin
            v0 = n_valid; p0 = n_perr; f0 = n_ferr;
            send_frame(vecs[i].data, vecs[i].par, vecs[i].stop, vecs[i].hold_bits);
            wait_clk(BIT_CLK);
            check_counts($sformatf("vec%0d", i), v0, p0, f0,
                         vecs[i].exp_v, vecs[i].exp_p, vecs[i].exp_f);
            check($sformatf("vec%0d_data", i), Rx_DATA, vecs[i].exp_data);
        end

        // 4-tick low glitch must be rejected at the start-bit midpoint
        v0 = n_valid; p0 = n_perr; f0 = n_ferr;
        RxD = 1'b0;
        wait_clk(4 * 27);
        RxD = 1'b1;
        wait_clk(12 * 27);
        check("glitch_state", dut.state, IDLE);
        wait_clk(BIT_CLK);
        check_counts("glitch", v0, p0, f0, 0, 0, 0);
        check("glitch_data", Rx_DATA, 8'h7F);

        // Rx_EN dropped during data bit 3; 0xFD keeps the line high afterwards
        v0 = n_valid; p0 = n_perr; f0 = n_ferr;
        fork
            send_frame(8'hFD, 1'b1, 1'b1, 0);
            begin
                wait_clk(4 * BIT_CLK + BIT_CLK / 2);
                Rx_EN = 1'b0;
                wait_clk(10);
                Rx_EN = 1'b1;
            end
        join
        wait_clk(BIT_CLK);
        check_counts("en_abort", v0, p0, f0, 0, 0, 0);
        check("en_abort_data", Rx_DATA, 8'h7F);
        v0 = n_valid; p0 = n_perr; f0 = n_ferr;
        send_frame(8'h5A, 1'b0, 1'b1, 0);
        wait_clk(BIT_CLK);
        check_counts("en_5a", v0, p0, f0, 1, 0, 0);
        check("en_5a_data", Rx_DATA, 8'h5A);

        // reset during data bit 4 of 0xF1 (line stays high from there on)
        fork
            send_frame(8'hF1, 1'b1, 1'b1, 0);
            begin
                wait_clk(5 * BIT_CLK + BIT_CLK / 2);
                reset = 1'b1;
                #1;
                check("mid_rst_data",  Rx_DATA, 8'h00);
                check("mid_rst_valid", Rx_VALID, 0);
                check("mid_rst_state", dut.state, IDLE);
                wait_clk(3);
                reset = 1'b0;
            end
        join
        wait_clk(BIT_CLK);
        v0 = n_valid; p0 = n_perr; f0 = n_ferr;
        send_frame(8'hFF, 1'b0, 1'b1, 0);
        wait_clk(BIT_CLK);
        check_counts("post_rst", v0, p0, f0, 1, 0, 0);
        check("post_rst_data", Rx_DATA, 8'hFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
